// File: rtl/tick_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_controller_pkg
// Description : Shared state encoding and default constants for the
//               tick_controller divide-by-N tick scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_controller_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default build parameters: 1 s tick off a 50 MHz board clock
    localparam int c_default_cnt_w = 26;
    localparam int c_default_div   = 50000000;

    // Smallest divide ratio that still yields a distinct one-cycle tick
    localparam int MIN_DIV = 2;

endpackage : tick_controller_pkg
`default_nettype wire

// File: rtl/tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : tick_counter
// Description : CNT_W-bit divide counter with clear, enable and terminal
//               compare against a divide ratio; emits a registered one-cycle
//               pulse on the edge after the terminal count is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_counter
    import tick_controller_pkg::*;
#(
    parameter int CNT_W = c_default_cnt_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_term,
    output logic             o_pulse
);

    logic [CNT_W-1:0] r_count;
    logic             r_pulse;

    // Terminal count is only honoured when running and not being cleared,
    // so stop/re-arm on the terminal edge suppresses the tick.
    assign o_term  = i_en && !i_clr && (r_count == (i_div - CNT_W'(1)));
    assign o_pulse = r_pulse;

    // Counter: held at zero while disabled or cleared, wraps at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr || !i_en || o_term) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Registered terminal pulse, high for exactly one cycle per terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= o_term;
        end
    end

endmodule : tick_counter
`default_nettype wire

// File: rtl/tick_controller.sv
`default_nettype none
// ============================================================================
// Module      : tick_controller
// Description : Programmable tick scheduler. Produces one-cycle clock-enable
//               pulses (tick) and a square wave (sq_out) from clock_50, with
//               periodic / one-shot modes, run/stop control and a valid/ready
//               divide-ratio config port.
//               Optional macro TICK_CONTROLLER_TICK_COUNT_EN adds an 8-bit
//               wrapping tick counter output (tick_count).
// Revision    : 1.0 - initial release
// ============================================================================
module tick_controller
    import tick_controller_pkg::*;
#(
    parameter int CNT_W       = c_default_cnt_w,
    parameter int DEFAULT_DIV = c_default_div
) (
    input  logic             clock_50,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             sq_out,
    output logic             busy,
`ifdef TICK_CONTROLLER_TICK_COUNT_EN
    output logic [7:0]       tick_count,
`endif
    output logic             done
);

    localparam logic [CNT_W-1:0] c_min_div   = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] c_reset_div = CNT_W'(DEFAULT_DIV);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_div;
    logic             r_oneshot;
    logic             r_sq;
    logic             w_cfg_load;
    logic [CNT_W-1:0] w_cfg_div_eff;
    logic             w_clr;
    logic             w_run;
    logic             w_term;
    logic             w_start_fresh;

    assign w_run         = (r_state == RUN);
    assign cfg_ready     = !w_run;
    assign busy          = w_run;
    assign done          = (r_state == DONE);
    assign sq_out        = r_sq;
    assign w_clr         = stop || start;
    assign w_cfg_load    = cfg_valid && cfg_ready;
    assign w_start_fresh = start && !stop && !w_run;
    assign w_cfg_div_eff = (cfg_div < c_min_div) ? c_min_div : cfg_div;

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .clk     (clock_50),
        .rst_n   (reset),
        .i_clr   (w_clr),
        .i_en    (w_run),
        .i_div   (r_div),
        .o_term  (w_term),
        .o_pulse (tick)
    );

    // FSM state register
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: stop beats start beats terminal count
    always_comb begin
        w_next_state = r_state;
        if (stop) begin
            w_next_state = IDLE;
        end else if (start) begin
            w_next_state = RUN;
        end else if (w_term && r_oneshot) begin
            w_next_state = DONE;
        end
    end

    // Config registers, only writable outside RUN so a run never sees a change
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            r_div     <= c_reset_div;
            r_oneshot <= 1'b0;
        end else if (w_cfg_load) begin
            r_div     <= w_cfg_div_eff;
            r_oneshot <= cfg_oneshot;
        end
    end

    // Square wave toggles on every accepted terminal count
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            r_sq <= 1'b0;
        end else if (w_term) begin
            r_sq <= !r_sq;
        end
    end

`ifdef TICK_CONTROLLER_TICK_COUNT_EN
    logic [7:0] r_tick_count;

    assign tick_count = r_tick_count;

    // Tick counter: cleared by a fresh start, survives a re-arm, wraps at 255
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            r_tick_count <= 8'd0;
        end else if (w_start_fresh) begin
            r_tick_count <= 8'd0;
        end else if (w_term) begin
            r_tick_count <= r_tick_count + 8'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_start_fresh;
`endif

endmodule : tick_controller
`default_nettype wire

// File: doc/tick_controller.md
# tick_controller

Programmable tick scheduler that sequences a divide-by-N counter off `clock_50`. It produces single-cycle clock-enable pulses (`tick`) and a legacy square wave (`sq_out`), and supports periodic or one-shot operation with run/stop control. Downstream logic consumes `tick` as an enable, so it never needs a derived clock. The divide ratio is loaded through a valid/ready config port, and the block sits between the board clock and every timed FSM in the design.

## Interface
- `CNT_W`, default 26: width of the divide counter and of `cfg_div`.
- `DEFAULT_DIV`, default 50000000: divide ratio loaded at reset.
- `clock_50` input 1: system clock, 50 MHz.
- `reset` input 1: asynchronous, active-low reset.
- `cfg_valid` input 1: config request.
- `cfg_ready` output 1: config accepted this cycle when high together with `cfg_valid`.
- `cfg_div` input CNT_W: new divide ratio, i.e. cycles per tick.
- `cfg_oneshot` input 1: new mode; 0 = periodic, 1 = one-shot.
- `start` input 1: arm or re-arm the counter.
- `stop` input 1: abort the run and return to IDLE.
- `tick` output 1: one-cycle enable pulse.
- `sq_out` output 1: toggles on every tick.
- `busy` output 1: high in RUN.
- `done` output 1: high in DONE (one-shot completed).
- `tick_count` output 8: tick counter. Present only with the macro; see Configuration.

## Operation
- States and their encoding:
  - IDLE = 0: counter held at 0.
  - RUN = 1: counter advancing.
  - DONE = 2: one-shot finished, counter held at 0.
- Reset values:
  - state IDLE, counter 0.
  - div register DEFAULT_DIV, mode periodic.
  - `tick` 0, `sq_out` 0, `busy` 0, `done` 0, `cfg_ready` 1, `tick_count` 0.
- Config handshake:
  - `cfg_ready` = (state != RUN), combinational.
  - On an edge with `cfg_valid && cfg_ready`, the div and mode registers are loaded and take effect at the next `start`.
  - A `cfg_div` value of 0 or 1 is stored as 2, so the minimum period is 2 cycles.
  - `cfg_valid` while in RUN is ignored; the requester must hold it until `cfg_ready` is high.
- Transitions, in priority order:
  - `stop` in any state → IDLE, counter cleared, `done` cleared. `stop` beats `start` and beats terminal count, so no tick is emitted on that edge.
  - `start` from IDLE or DONE → RUN, counter cleared to 0, `done` cleared.
  - `start` in RUN → stays in RUN, counter cleared to 0 (re-arm); no tick on that edge even at terminal count.
  - RUN with counter == div−1:
    - counter → 0, `tick` high for the next cycle, `sq_out` toggles.
    - If one-shot: → DONE.
    - If periodic: stay in RUN.
  - RUN otherwise: counter +1.
- `tick` is registered and high for exactly one cycle per terminal count; it is never high in IDLE.
- `sq_out` holds its level through stop, start and DONE; only reset clears it.

## Timing
- If `start` is sampled at edge 0, `tick` is high after edges div, 2·div, 3·div, …
- `sq_out` period is 2·div cycles. With DEFAULT_DIV this is 0.5 Hz at 50 MHz, matching the existing 1 s half-period toggle.
- One-shot: `tick` and `done` rise together after edge div. `busy` falls on that same edge.
- `busy` rises one edge after `start` is sampled; `cfg_ready` falls with it.
- Reset assertion mid-run forces all outputs to their reset values immediately (asynchronously). The next run starts only on a fresh `start`.

## Configuration
- Macro: `TICK_CONTROLLER_TICK_COUNT_EN`.
- When defined:
  - `tick_count` increments on every tick and wraps 255 → 0.
  - It is cleared by reset and by `start` from IDLE or DONE.
  - It is not cleared by a re-arm `start` in RUN.
- When not defined: the port and its register are absent, and all other behaviour is identical.

## Structure
- Package `tick_controller_pkg` holds:
  - the state encoding constants IDLE/RUN/DONE;
  - the default values of `CNT_W` and `DEFAULT_DIV`;
  - `MIN_DIV` = 2.
- Sub-module `tick_counter`:
  - contains the CNT_W counter with clear, enable and terminal-compare against div;
  - outputs a registered terminal pulse.
- The top level contains the FSM, the config registers, `sq_out` and the optional `tick_count`.

## Test plan
- Reset, then load cfg_div=4 in periodic mode, then start at edge 0 → `tick` pulses after edges 4, 8, 12; `sq_out` toggles at each pulse; `busy`=1 and `cfg_ready`=0 throughout.
- cfg_div=3 with one-shot → single `tick` after edge 3; `done`=1 and `busy`=0 from then on; a new `start` clears `done` and the next tick comes 3 cycles later.
- cfg_div=0 → behaves as 2, with ticks every 2 cycles.
- Periodic run with div=5, `stop` asserted on the edge where the counter is 4 → no tick, state IDLE, and `sq_out` keeps its level.
- `start` and `stop` in the same cycle, then `cfg_valid` during RUN → state stays IDLE; the cfg load is stalled until after stop; a re-arm `start` at counter 2 delays the next tick to div cycles later.
- With the macro defined, 260 ticks at div=2 → `tick_count`=4; `reset` pulsed low mid-run → all outputs at their reset values immediately.
